// File: rtl/divider.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per cycle,
// results registered and announced with a single-cycle o_finished pulse.
module divider #(
    parameter int N = 8
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_start,
    input  logic [N-1:0] i_dividend,
    input  logic [N-1:0] i_divisor,
    output logic         o_busy,
    output logic         o_finished,
    output logic [N-1:0] o_quotient,
    output logic [N-1:0] o_remainder,
    output logic         o_divide_by_zero
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [N-1:0]  dividend;
    logic [N-1:0]  divisor;
    logic [N-1:0]  partial;
    logic [N:0]    trial;
    logic [N-1:0]  diff;
    logic          fits;

    // partial < divisor always holds, so trial - divisor fits in N bits when taken
    always_comb begin
        trial = {partial, dividend[N-1]};
        diff  = trial[N-1:0] - divisor;
        fits  = (trial >= {1'b0, divisor});
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state            <= IDLE;
            count            <= '0;
            dividend         <= '0;
            divisor          <= '0;
            partial          <= '0;
            o_busy           <= 1'b0;
            o_finished       <= 1'b0;
            o_quotient       <= '0;
            o_remainder      <= '0;
            o_divide_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_finished <= 1'b0;
                    if (i_start) begin
                        dividend <= i_dividend;
                        divisor  <= i_divisor;
                        partial  <= '0;
                        count    <= '0;
                        o_busy   <= 1'b1;
                        state    <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (count == CW'(N)) begin
                        // dividend register now holds the quotient bits; with a zero
                        // divisor the partial remainder has accumulated the whole dividend
                        state            <= DONE;
                        o_busy           <= 1'b0;
                        o_finished       <= 1'b1;
                        o_quotient       <= (divisor == '0) ? '1 : dividend;
                        o_remainder      <= partial;
                        o_divide_by_zero <= (divisor == '0);
                    end else begin
                        partial  <= fits ? diff : trial[N-1:0];
                        dividend <= {dividend[N-2:0], fits};
                        count    <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: directed cases on an 8-bit instance, then
// concurrent back-to-back random streams on 8-bit and 16-bit instances.
module tb_divider;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int unsigned cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  a8, b8;
    logic [15:0] a16, b16;
    logic        busy8, fin8, dbz8;
    logic [7:0]  q8, r8;
    logic        busy16, fin16, dbz16;
    logic [15:0] q16, r16;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned cyc      = 0;
    exp_t        sb8[$];
    exp_t        sb16[$];

    divider #(.N(8)) dut8 (
        .i_clock(clk), .i_reset(rst), .i_start(start8),
        .i_dividend(a8), .i_divisor(b8),
        .o_busy(busy8), .o_finished(fin8),
        .o_quotient(q8), .o_remainder(r8), .o_divide_by_zero(dbz8)
    );

    divider #(.N(16)) dut16 (
        .i_clock(clk), .i_reset(rst), .i_start(start16),
        .i_dividend(a16), .i_divisor(b16),
        .o_busy(busy16), .o_finished(fin16),
        .o_quotient(q16), .o_remainder(r16), .o_divide_by_zero(dbz16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: q*d + r = a with r < d; zero divisor gives all-ones quotient and r = a.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic [15:0] ones, input int unsigned c);
        exp_t e;
        if (b == 16'd0) begin
            e.q = ones;
            e.r = a;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = a % b;
            e.z = 1'b0;
        end
        e.cyc = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (fin8) begin
            if (sb8.size() != 0) begin
                exp_t e;
                e = sb8.pop_front();
                check("q8", 32'(q8), 32'(e.q));
                check("r8", 32'(r8), 32'(e.r));
                check("dbz8", 32'(dbz8), 32'(e.z));
                check("lat8", cyc, e.cyc);
                check("busy_done8", 32'(busy8), 0);
            end else begin
                check("stray_finish8", 32'(fin8), 0);
            end
        end
    end

    always @(negedge clk) begin
        if (fin16) begin
            if (sb16.size() != 0) begin
                exp_t e;
                e = sb16.pop_front();
                check("q16", 32'(q16), 32'(e.q));
                check("r16", 32'(r16), 32'(e.r));
                check("dbz16", 32'(dbz16), 32'(e.z));
                check("lat16", cyc, e.cyc);
            end else begin
                check("stray_finish16", 32'(fin16), 0);
            end
        end
    end

    // Drive a one-cycle start at the current negedge and record the expected result.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        sb8.push_back(model(16'(a), 16'(b), 16'h00FF, cyc + 10));
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic wait_fin8();
        for (int w = 0; w < 20 && !fin8; w++) @(negedge clk);
        check("wait_fin8", 32'(fin8), 1);
    endtask

    task automatic drain8();
        for (int w = 0; w < 40 && sb8.size() != 0; w++) @(negedge clk);
        check("drain8", sb8.size(), 0);
    endtask

    task automatic drain16();
        for (int w = 0; w < 60 && sb16.size() != 0; w++) @(negedge clk);
        check("drain16", sb16.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        start8 = 1'b0;
        start16 = 1'b0;
        a8 = '0; b8 = '0; a16 = '0; b16 = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy8), 0);
        check("rst_fin", 32'(fin8), 0);
        check("rst_q", 32'(q8), 0);
        check("rst_r", 32'(r8), 0);
        check("rst_dbz", 32'(dbz8), 0);
        rst = 1'b0;
        @(negedge clk);

        // 100/7 with latency, busy and result hold
        issue8(8'd100, 8'd7);
        check("busy_run", 32'(busy8), 1);
        a8 = 8'd1;
        b8 = 8'd1;
        drain8();
        @(negedge clk);
        check("idle_busy", 32'(busy8), 0);
        check("pulse_once", 32'(fin8), 0);
        check("hold_q", 32'(q8), 14);
        check("hold_r", 32'(r8), 2);

        // back-to-back: second start in the DONE cycle
        issue8(8'd255, 8'd1);
        wait_fin8();
        issue8(8'd3, 8'd10);
        check("b2b_busy", 32'(busy8), 1);
        drain8();

        // divide by zero
        issue8(8'd5, 8'd0);
        drain8();

        // start pulse during RUN is ignored
        issue8(8'd200, 8'd9);
        repeat (2) @(negedge clk);
        a8 = 8'd50;
        b8 = 8'd5;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        drain8();

        // reset with start at RUN cycle 4 aborts without a finish pulse
        a8 = 8'd17;
        b8 = 8'd3;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy8), 1);
        rst = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start8 = 1'b0;
        check("abort_busy", 32'(busy8), 0);
        check("abort_fin", 32'(fin8), 0);
        check("abort_q", 32'(q8), 0);
        check("abort_r", 32'(r8), 0);
        check("abort_dbz", 32'(dbz8), 0);
        repeat (12) @(negedge clk);
        check("abort_idle", 32'(busy8), 0);
        issue8(8'd81, 8'd9);
        drain8();

        // random back-to-back streams on both widths
        fork
            begin
                logic [7:0] ra, rb;
                for (int i = 0; i < 7000; i++) begin
                    ra = 8'($urandom);
                    rb = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom);
                    a8 = ra;
                    b8 = rb;
                    start8 = 1'b1;
                    sb8.push_back(model(16'(ra), 16'(rb), 16'h00FF, cyc + 10));
                    @(negedge clk);
                    start8 = 1'b0;
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                    for (int w = 0; w < 20 && !fin8; w++) @(negedge clk);
                    check("rnd_wait8", 32'(fin8), 1);
                end
            end
            begin
                logic [15:0] sa, sbv;
                for (int i = 0; i < 3500; i++) begin
                    sa = 16'($urandom);
                    sbv = ($urandom_range(0, 19) == 0) ? 16'd0 :
                          ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom);
                    a16 = sa;
                    b16 = sbv;
                    start16 = 1'b1;
                    sb16.push_back(model(sa, sbv, 16'hFFFF, cyc + 18));
                    @(negedge clk);
                    start16 = 1'b0;
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                    for (int w = 0; w < 30 && !fin16; w++) @(negedge clk);
                    check("rnd_wait16", 32'(fin16), 1);
                end
            end
        join

        @(negedge clk);
        drain8();
        drain16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 Parameter N, default 8, operand and result width in bits; N >= 2.
REQ-002 i_clock  input  1  clock; all state changes on its rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_start  input  1  request a division; sampled every rising edge.
REQ-005 i_dividend  input  N  unsigned dividend; sampled only on an accepted start.
REQ-006 i_divisor  input  N  unsigned divisor; sampled only on an accepted start.
REQ-007 o_busy  output  1  high while a division is in progress.
REQ-008 o_finished  output  1  one-cycle pulse; results valid.
REQ-009 o_quotient  output  N  unsigned quotient, registered.
REQ-010 o_remainder  output  N  unsigned remainder, registered.
REQ-011 o_divide_by_zero  output  1  high with results when the latched divisor was 0.

Function
REQ-012 The algorithm SHALL be restoring shift-subtract division, producing one quotient bit per cycle, MSB first.
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-014 The start SHALL be accepted when i_start=1 and state is IDLE or DONE; the block latches the operands, clears the partial remainder and the iteration counter, and enters RUN.
REQ-015 i_start in RUN SHALL be ignored: no effect on operands, counter or results.
REQ-016 Each RUN cycle SHALL form an (N+1)-bit trial = {partial remainder, next dividend bit}; if trial >= divisor, then remainder = trial - divisor and quotient bit = 1, else remainder = trial and quotient bit = 0.
REQ-017 The counter SHALL be ceil(log2(N+1)) bits wide; after exactly N RUN cycles the FSM SHALL move to DONE.
REQ-018 Latency: if the start is accepted at edge k, o_finished SHALL be high for exactly the cycle after edge k+N+1 (N+1 cycles after acceptance).
REQ-019 In DONE the FSM SHALL return to IDLE, unless a start is accepted in the same cycle, in which case it enters RUN (back-to-back operations).
REQ-020 o_busy SHALL be high exactly while state is RUN.
REQ-021 o_quotient, o_remainder and o_divide_by_zero SHALL update only on the edge entering DONE and hold their values until the next DONE entry or reset.
REQ-022 Divisor 0: the block SHALL still take the full latency; results SHALL be o_quotient = all ones, o_remainder = latched dividend, o_divide_by_zero = 1.
REQ-023 Nonzero divisor: results SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor, and o_divide_by_zero = 0.
REQ-024 Changes to i_dividend or i_divisor after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-025 i_reset SHALL take priority over i_start and abort any operation in progress.
REQ-026 After reset: state IDLE, counter 0, o_busy=0, o_finished=0, o_quotient=0, o_remainder=0, o_divide_by_zero=0.
REQ-027 A division aborted by reset SHALL NOT produce an o_finished pulse.

Verification
REQ-028 N=8, 100/7 with a start pulse -> o_finished exactly 9 cycles after acceptance; quotient 14, remainder 2, o_divide_by_zero 0.
REQ-029 N=8, 255/1 and 3/10 back-to-back (second start in the DONE cycle) -> 255 r 0, then 0 r 3; no idle gap between operations.
REQ-030 N=8, 5/0 -> quotient 255, remainder 5, o_divide_by_zero 1, standard latency.
REQ-031 Start 200/9, re-pulse i_start with 50/5 during RUN -> the second pulse is ignored; result 22 r 2 at the original latency.
REQ-032 Reset asserted at RUN cycle 4, together with i_start -> all outputs 0, o_busy 0, no o_finished pulse; a later start 81/9 -> 9 r 0.
REQ-033 Random unsigned operands with N=8 and N=16, at least 10k operations -> every result matches the reference model of REQ-022 and REQ-023.
